// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Brief    : Machine-mode CSR file with trap/MRET handling and 64-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter bit              CNT_EN      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            instret_inc,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_enable
);

    localparam logic [1:0]  C_OP_NONE = 2'b00;
    localparam logic [1:0]  C_OP_RW   = 2'b01;
    localparam logic [1:0]  C_OP_RS   = 2'b10;
    localparam logic [1:0]  C_OP_RC   = 2'b11;

    localparam logic [11:0] C_ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] C_ADDR_MISA      = 12'h301;
    localparam logic [11:0] C_ADDR_MIE       = 12'h304;
    localparam logic [11:0] C_ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] C_ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] C_ADDR_MEPC      = 12'h341;
    localparam logic [11:0] C_ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] C_ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] C_ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] C_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] C_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] C_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] C_ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] C_ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] C_ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] C_ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] C_ADDR_INSTRETH  = 12'hC82;

    localparam logic [XLEN-1:0] C_MISA_VAL   = 32'h4000_0100;
    localparam logic [XLEN-1:0] C_MIE_MASK   = 32'h0000_0888;
    localparam logic [XLEN-1:0] C_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    logic [63:0]     w_mcycle;
    logic [63:0]     w_minstret;
    logic [XLEN-1:0] w_rval;
    logic            w_impl;
    logic            w_illegal;
    logic            w_wr;
    logic [XLEN-1:0] w_new;

    always_comb begin
        w_impl = 1'b1;
        w_rval = '0;
        case (csr_addr)
            C_ADDR_MSTATUS:  w_rval = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
            C_ADDR_MISA:     w_rval = C_MISA_VAL;
            C_ADDR_MIE:      w_rval = r_mie;
            C_ADDR_MTVEC:    w_rval = r_mtvec;
            C_ADDR_MSCRATCH: w_rval = r_mscratch;
            C_ADDR_MEPC:     w_rval = r_mepc;
            C_ADDR_MCAUSE:   w_rval = r_mcause;
            C_ADDR_MTVAL:    w_rval = r_mtval;
            C_ADDR_MHARTID:  w_rval = HART_ID;
            C_ADDR_MCYCLE, C_ADDR_CYCLE: begin
                w_impl = CNT_EN;
                w_rval = w_mcycle[31:0];
            end
            C_ADDR_MCYCLEH, C_ADDR_CYCLEH: begin
                w_impl = CNT_EN;
                w_rval = w_mcycle[63:32];
            end
            C_ADDR_MINSTRET, C_ADDR_INSTRET: begin
                w_impl = CNT_EN;
                w_rval = w_minstret[31:0];
            end
            C_ADDR_MINSTRETH, C_ADDR_INSTRETH: begin
                w_impl = CNT_EN;
                w_rval = w_minstret[63:32];
            end
            default:         w_impl = 1'b0;
        endcase
    end

    // Addresses 0xC00-0xFFF are read-only space: any op that would modify them traps.
    assign w_illegal = (csr_op != C_OP_NONE) &&
                       (!w_impl || ((csr_addr[11:10] == 2'b11) &&
                                    ((csr_op == C_OP_RW) || (csr_wdata != '0))));

    // Set/clear with an all-zero mask is a pure read and must not stall counters.
    assign w_wr = (csr_op != C_OP_NONE) && !w_illegal &&
                  ((csr_op == C_OP_RW) || (csr_wdata != '0));

    always_comb begin
        w_new = w_rval;
        case (csr_op)
            C_OP_RW: w_new = csr_wdata;
            C_OP_RS: w_new = w_rval | csr_wdata;
            C_OP_RC: w_new = w_rval & ~csr_wdata;
            default: w_new = w_rval;
        endcase
    end

    assign csr_rdata   = w_illegal ? '0 : w_rval;
    assign csr_illegal = w_illegal;
    assign trap_vector = r_mtvec;
    assign mepc_out    = r_mepc;
    assign irq_enable  = r_mstatus_mie;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RESET & C_ALIGN_MASK;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else begin
            if (trap_valid) begin
                r_mepc         <= trap_pc & C_ALIGN_MASK;
                r_mcause       <= trap_cause;
                r_mtval        <= trap_tval;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (mret_valid) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_wr) begin
                case (csr_addr)
                    C_ADDR_MSTATUS: begin
                        r_mstatus_mie  <= w_new[3];
                        r_mstatus_mpie <= w_new[7];
                    end
                    C_ADDR_MEPC:   r_mepc   <= w_new & C_ALIGN_MASK;
                    C_ADDR_MCAUSE: r_mcause <= w_new;
                    C_ADDR_MTVAL:  r_mtval  <= w_new;
                    default: ;
                endcase
            end
            if (w_wr) begin
                case (csr_addr)
                    C_ADDR_MIE:      r_mie      <= w_new & C_MIE_MASK;
                    C_ADDR_MTVEC:    r_mtvec    <= w_new & C_ALIGN_MASK;
                    C_ADDR_MSCRATCH: r_mscratch <= w_new;
                    default: ;
                endcase
            end
        end
    end

    generate
        if (CNT_EN) begin : g_cnt
            logic [63:0] r_mcycle;
            logic [63:0] r_minstret;

            // A half-write replaces the increment; the 64-bit add carries into the high half.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mcycle   <= '0;
                    r_minstret <= '0;
                end else begin
                    if (w_wr && (csr_addr == C_ADDR_MCYCLE))
                        r_mcycle[31:0] <= w_new;
                    else if (w_wr && (csr_addr == C_ADDR_MCYCLEH))
                        r_mcycle[63:32] <= w_new;
                    else
                        r_mcycle <= r_mcycle + 64'd1;

                    if (w_wr && (csr_addr == C_ADDR_MINSTRET))
                        r_minstret[31:0] <= w_new;
                    else if (w_wr && (csr_addr == C_ADDR_MINSTRETH))
                        r_minstret[63:32] <= w_new;
                    else if (instret_inc)
                        r_minstret <= r_minstret + 64'd1;
                end
            end

            assign w_mcycle   = r_mcycle;
            assign w_minstret = r_minstret;
        end else begin : g_no_cnt
            assign w_mcycle   = '0;
            assign w_minstret = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Brief    : Directed self-checking bench for csr_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

    localparam logic [31:0] C_HART_ID     = 32'h0000_0005;
    localparam logic [31:0] C_MTVEC_RESET = 32'h0000_0203;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        mret_valid;
    logic        instret_inc;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;
    logic        irq_enable;

    int n_tests = 0;
    int n_fail  = 0;

    csr_file #(
        .XLEN        (32),
        .HART_ID     (C_HART_ID),
        .MTVEC_RESET (C_MTVEC_RESET),
        .CNT_EN      (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .trap_valid  (trap_valid),
        .trap_pc     (trap_pc),
        .trap_cause  (trap_cause),
        .trap_tval   (trap_tval),
        .mret_valid  (mret_valid),
        .instret_inc (instret_inc),
        .trap_vector (trap_vector),
        .mepc_out    (mepc_out),
        .irq_enable  (irq_enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        access(2'b00, addr, 32'h0);
        chk(tag, csr_rdata, exp);
    endtask

    initial begin
        rst = 1'b1;
        csr_addr = 12'h0; csr_op = 2'b00; csr_wdata = 32'h0;
        trap_valid = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0; trap_tval = 32'h0;
        mret_valid = 1'b0; instret_inc = 1'b0;

        // Reset state
        step(); step();
        chk("rst_trap_vector", trap_vector, 32'h0000_0200);
        chk("rst_irq_enable", {31'd0, irq_enable}, 32'h0);
        chk("rst_mepc_out", mepc_out, 32'h0);
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("rst_misa", 12'h301, 32'h4000_0100);
        rd_chk("rst_mcycle", 12'hB00, 32'h0);
        rst = 1'b0;
        #1;
        rd_chk("mcycle_after_release", 12'hB00, 32'h0);
        step();
        rd_chk("mcycle_first_edge", 12'hB00, 32'h1);

        // mtvec write, no output bypass
        access(2'b01, 12'h305, 32'h8000_0103);
        chk("mtvec_no_bypass", trap_vector, 32'h0000_0200);
        step();
        rd_chk("mtvec_read", 12'h305, 32'h8000_0100);
        chk("mtvec_trap_vector", trap_vector, 32'h8000_0100);

        // mie implemented bits, mscratch RC
        access(2'b01, 12'h304, 32'hFFFF_FFFF);
        step();
        rd_chk("mie_mask", 12'h304, 32'h0000_0888);
        access(2'b01, 12'h340, 32'hF0F0_1234);
        step();
        access(2'b11, 12'h340, 32'h0000_1030);
        chk("mscratch_rc_preupdate", csr_rdata, 32'hF0F0_1234);
        step();
        rd_chk("mscratch_rc", 12'h340, 32'hF0F0_0204);

        // mstatus set, trap entry, mret
        access(2'b10, 12'h300, 32'h0000_0008);
        step();
        rd_chk("mstatus_rs", 12'h300, 32'h0000_1808);
        chk("irq_enable_set", {31'd0, irq_enable}, 32'h1);
        trap_valid = 1'b1; trap_pc = 32'h0000_1006; trap_cause = 32'd11; trap_tval = 32'hDEAD_BEEF;
        step();
        trap_valid = 1'b0;
        chk("trap_mepc_out", mepc_out, 32'h0000_1004);
        rd_chk("trap_mcause", 12'h342, 32'd11);
        rd_chk("trap_mtval", 12'h343, 32'hDEAD_BEEF);
        rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);
        chk("trap_irq_enable", {31'd0, irq_enable}, 32'h0);
        mret_valid = 1'b1;
        step();
        mret_valid = 1'b0;
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        chk("mret_irq_enable", {31'd0, irq_enable}, 32'h1);

        // mcycle carry across halves
        access(2'b01, 12'hB00, 32'hFFFF_FFFF);
        step();
        access(2'b01, 12'hB80, 32'h0);
        step();
        rd_chk("mcycle_loaded_lo", 12'hB00, 32'hFFFF_FFFF);
        step();
        rd_chk("mcycleh_carry", 12'hB80, 32'h1);
        rd_chk("mcycle_wrap", 12'hB00, 32'h0);
        rd_chk("cycleh_shadow", 12'hC80, 32'h1);

        // Illegal accesses and read-only legality
        access(2'b01, 12'hC00, 32'h5);
        chk("cycle_rw_illegal", {31'd0, csr_illegal}, 32'h1);
        chk("cycle_rw_rdata", csr_rdata, 32'h0);
        step();
        rd_chk("cycle_unaffected", 12'hC00, 32'h1);
        access(2'b10, 12'h7C0, 32'h0);
        chk("unimpl_illegal", {31'd0, csr_illegal}, 32'h1);
        chk("unimpl_rdata", csr_rdata, 32'h0);
        access(2'b10, 12'hF14, 32'h0);
        chk("mhartid_rs0_legal", {31'd0, csr_illegal}, 32'h0);
        chk("mhartid_rs0_rdata", csr_rdata, C_HART_ID);

        // Trap beats CSR write to mepc; other CSR writes still land
        access(2'b01, 12'h341, 32'h0000_0100);
        trap_valid = 1'b1; trap_pc = 32'h0000_2003; trap_cause = 32'd2; trap_tval = 32'h0;
        step();
        access(2'b01, 12'h340, 32'h0000_0055);
        step();
        trap_valid = 1'b0;
        chk("trap_over_mepc_write", mepc_out, 32'h0000_2000);
        rd_chk("write_during_trap", 12'h340, 32'h0000_0055);

        // minstret counts retired instructions only
        rd_chk("minstret_idle", 12'hB02, 32'h0);
        instret_inc = 1'b1;
        for (int i = 0; i < 10; i++) step();
        instret_inc = 1'b0;
        rd_chk("minstret_10", 12'hB02, 32'd10);
        rd_chk("instret_shadow", 12'hC02, 32'd10);
        rd_chk("minstreth_0", 12'hB82, 32'h0);

        // Asynchronous reset mid-operation
        access(2'b01, 12'h305, 32'h1234_5678);
        rst = 1'b1;
        #1;
        chk("async_rst_trap_vector", trap_vector, 32'h0000_0200);
        chk("async_rst_mepc", mepc_out, 32'h0);
        rd_chk("async_rst_mcycle", 12'hB00, 32'h0);
        step();
        rd_chk("async_rst_mtvec_held", 12'h305, 32'h0000_0200);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
